ts_null_stuffer: RTL and testbench
==================================

// Module: ts_null_stuffer
// PURPOSE
//  Downstream of the T2-MI-over-TS packer. Buffers its bursty 188-byte TS packets (ENA/PSYNC framed, gaps allowed)
//  and re-emits them at a constant byte rate set by TICK. When no complete packet is buffered, it inserts
//  null packets, so the modulator/ASI side always sees an unbroken, packet-aligned TS.
// PARAMETERS
//  FIFO_PKTS  4        buffer depth in whole TS packets; RAM = FIFO_PKTS*188 bytes
//  NULL_PID   13'h1FFF PID placed in stuffed packets
// PORTS
//  CLK        in   1   system clock; all logic on rising edge
//  RST        in   1   synchronous, active-high reset
//  DATA_IN    in   8   TS byte from packer
//  ENA_IN     in   1   DATA_IN valid
//  PSYNC_IN   in   1   with ENA_IN: byte 0 (0x47) of a packet
//  TICK       in   1   output byte-slot strobe; one output byte per TICK
//  DATA_OUT   out  8   output TS byte
//  ENA_OUT    out  1   1-cycle pulse, DATA_OUT valid
//  PSYNC_OUT  out  1   with ENA_OUT: byte 0 of an output packet
//  OVF        out  1   sticky: a packet was dropped; cleared only by RST
//  NULL_CNT   out  16  stuffed-packet count (STUFF_STATS_EN only)
//  DROP_CNT   out  16  dropped-packet count (STUFF_STATS_EN only)
// BEHAVIOUR
//  Reset: DATA_OUT=0, ENA_OUT=0, PSYNC_OUT=0, OVF=0, counters=0, FIFO empty, out state IDLE, in state HUNT.
//  RST mid-packet discards all buffered and partial data; the next output slot starts a fresh packet.
//  Write side (states HUNT, FILL):
//   - HUNT: ignore bytes until ENA_IN&PSYNC_IN. Then, if free bytes>=188, write byte, wcnt=1, go FILL.
//     Otherwise drop the whole packet: set OVF, DROP_CNT++, stay HUNT.
//   - FILL: each ENA_IN byte is written and wcnt++. At wcnt==188, commit: pkt_cnt++, go HUNT.
//   - PSYNC_IN inside FILL (short packet): rewind write ptr to packet start, DROP_CNT++, OVF=1.
//     Treat this byte as a new HUNT start in the same cycle.
//  Committed-packet accounting:
//   - pkt_cnt counts committed packets not yet started on output.
//   - Commit and output-start in the same cycle leave pkt_cnt unchanged.
//   - Free bytes = FIFO_PKTS*188 - (write ptr - read ptr) mod depth. Pointers wrap at depth.
//  Read side (states IDLE, DATA, NULL), advancing only on TICK:
//   - IDLE/end of packet: on TICK, choose DATA if registered pkt_cnt>0, else NULL.
//     A packet committed in the same cycle is not seen until the next slot.
//   - DATA: 188 TICKs read FIFO bytes in order; the first carries PSYNC_OUT.
//   - NULL: 188 TICKs emit 47, {3'b000,NULL_PID[12:8]}, NULL_PID[7:0], 8'h10, then 184x FF.
//     PSYNC_OUT on the 47.
//   - Output packets never interleave; the choice is made only at the 188-byte boundary.
//   - Latency: DATA_OUT/ENA_OUT/PSYNC_OUT registered, valid the cycle after TICK (sync RAM read fits).
//   - TICK on consecutive cycles is legal (full-rate); TICK is ignored during RST.
//  Counters 16-bit, saturate at FFFF.
// CONFIGURATION
//  STUFF_STATS_EN defined:
//   - NULL_CNT++ at the start of each null packet (first TICK); DROP_CNT++ on each drop.
//  STUFF_STATS_EN undefined:
//   - NULL_CNT and DROP_CNT tied to 0 and no counter logic. OVF is present in both builds.
// TESTING
//  1 No input, TICK every 4 clk -> continuous null packets 47 1F FF 10 FF..; PSYNC_OUT every 188th ENA_OUT;
//    with STUFF_STATS_EN, NULL_CNT=3 after 564 TICKs.
//  2 One packet (47 00 64 1x, payload inc 0..183) written with gaps while a null packet is mid-flight ->
//    null completes all 188 bytes, then the packet is output byte-exact, then nulls resume.
//  3 Write 5 full packets back-to-back, TICK off, FIFO_PKTS=4 -> 4 buffered, 5th dropped, OVF=1, DROP_CNT=1;
//    enabling TICK outputs exactly packets 1-4 in order.
//  4 Short packet (100 bytes, then PSYNC) -> partial discarded, DROP_CNT=1, OVF=1;
//    following full packet is output intact, no stray bytes.
//  5 Commit on the same cycle as the boundary TICK with pkt_cnt=0 -> null packet chosen,
//    the data packet follows in the next slot.
//  6 RST asserted mid-DATA packet for 1 cycle -> all outputs 0 next cycle, OVF=0;
//    first TICK after reset gives 47 with PSYNC_OUT=1 of a null packet.

Source files
------------

// File: rtl/ts_null_stuffer.sv
// ts_null_stuffer: buffers bursty 188-byte TS packets and replays them one byte per TICK,
// filling empty slots with null packets. Define STUFF_STATS_EN to enable NULL_CNT/DROP_CNT.
module ts_null_stuffer #(
  parameter int          FIFO_PKTS = 4,
  parameter logic [12:0] NULL_PID  = 13'h1FFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  DATA_IN,
  input  logic        ENA_IN,
  input  logic        PSYNC_IN,
  input  logic        TICK,
  output logic [7:0]  DATA_OUT,
  output logic        ENA_OUT,
  output logic        PSYNC_OUT,
  output logic        OVF,
  output logic [15:0] NULL_CNT,
  output logic [15:0] DROP_CNT
);

  localparam int PKT   = 188;
  localparam int DEPTH = FIFO_PKTS * PKT;
  localparam int AW    = $clog2(DEPTH);
  localparam int UW    = $clog2(DEPTH + 1);
  localparam int CW    = $clog2(FIFO_PKTS + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [UW-1:0] MAX_USED  = UW'(DEPTH - PKT);
  localparam logic [7:0]    LAST_IDX  = 8'd187;

  typedef enum logic {W_HUNT, W_FILL} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_DATA, R_NULL} rd_state_t;

  logic [7:0] mem [DEPTH];
  logic [7:0] rd_byte;

  wr_state_t     wr_state, wr_state_nxt;
  logic [AW-1:0] wptr, wptr_nxt, pkt_start, pkt_start_nxt, wr_addr;
  logic [7:0]    wcnt, wcnt_nxt;
  logic          wr_en, commit, drop, short_pkt, room;
  logic [UW-1:0] used, used_eff;
  logic [CW-1:0] pkt_cnt;

  rd_state_t     rd_state, rd_state_nxt;
  logic [AW-1:0] rptr, rptr_nxt;
  logic [7:0]    rcnt, rcnt_nxt;
  logic          rd_en, start_data, is_data;
  logic          ena_nxt, psync_nxt, sel_data, sel_data_nxt;
  logic [7:0]    null_byte, null_nxt;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [7:0] null_lut(input logic [7:0] idx);
    case (idx)
      8'd0:    return 8'h47;
      8'd1:    return {3'b000, NULL_PID[12:8]};
      8'd2:    return NULL_PID[7:0];
      8'd3:    return 8'h10;
      default: return 8'hFF;
    endcase
  endfunction

  // Write side: a PSYNC inside FILL rewinds to the packet start and restarts from that byte.
  always_comb begin
    short_pkt     = ENA_IN && PSYNC_IN && (wr_state == W_FILL);
    used_eff      = short_pkt ? used - UW'(wcnt) : used;
    room          = (used_eff <= MAX_USED);
    wr_state_nxt  = wr_state;
    wptr_nxt      = wptr;
    pkt_start_nxt = pkt_start;
    wcnt_nxt      = wcnt;
    wr_en         = 1'b0;
    wr_addr       = wptr;
    commit        = 1'b0;
    drop          = short_pkt;
    if (ENA_IN && PSYNC_IN) begin
      wr_addr = short_pkt ? pkt_start : wptr;
      if (room) begin
        wr_en         = 1'b1;
        wptr_nxt      = ptr_inc(wr_addr);
        pkt_start_nxt = wr_addr;
        wcnt_nxt      = 8'd1;
        wr_state_nxt  = W_FILL;
      end else begin
        drop         = 1'b1;
        wptr_nxt     = wr_addr;
        wcnt_nxt     = '0;
        wr_state_nxt = W_HUNT;
      end
    end else if (ENA_IN && (wr_state == W_FILL)) begin
      wr_en    = 1'b1;
      wptr_nxt = ptr_inc(wptr);
      if (wcnt == LAST_IDX) begin
        commit       = 1'b1;
        wcnt_nxt     = '0;
        wr_state_nxt = W_HUNT;
      end else begin
        wcnt_nxt = wcnt + 8'd1;
      end
    end
  end

  // Read side: the data/null choice is made only in IDLE, i.e. at a packet boundary.
  always_comb begin
    rd_state_nxt = rd_state;
    rptr_nxt     = rptr;
    rcnt_nxt     = rcnt;
    rd_en        = 1'b0;
    start_data   = 1'b0;
    is_data      = 1'b0;
    ena_nxt      = 1'b0;
    psync_nxt    = 1'b0;
    sel_data_nxt = sel_data;
    null_nxt     = null_byte;
    if (TICK) begin
      ena_nxt   = 1'b1;
      psync_nxt = (rcnt == 8'd0);
      case (rd_state)
        R_IDLE: begin
          if (pkt_cnt != '0) begin
            start_data   = 1'b1;
            is_data      = 1'b1;
            rd_state_nxt = R_DATA;
          end else begin
            rd_state_nxt = R_NULL;
          end
        end
        R_DATA:  is_data = 1'b1;
        default: is_data = 1'b0;
      endcase
      if (is_data) begin
        rd_en        = 1'b1;
        rptr_nxt     = ptr_inc(rptr);
        sel_data_nxt = 1'b1;
      end else begin
        sel_data_nxt = 1'b0;
        null_nxt     = null_lut(rcnt);
      end
      if (rcnt == LAST_IDX) begin
        rcnt_nxt     = '0;
        rd_state_nxt = R_IDLE;
      end else begin
        rcnt_nxt = rcnt + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_state  <= W_HUNT;
      wptr      <= '0;
      pkt_start <= '0;
      wcnt      <= '0;
      used      <= '0;
      pkt_cnt   <= '0;
      rd_state  <= R_IDLE;
      rptr      <= '0;
      rcnt      <= '0;
      ENA_OUT   <= 1'b0;
      PSYNC_OUT <= 1'b0;
      sel_data  <= 1'b0;
      null_byte <= '0;
      OVF       <= 1'b0;
    end else begin
      wr_state  <= wr_state_nxt;
      wptr      <= wptr_nxt;
      pkt_start <= pkt_start_nxt;
      wcnt      <= wcnt_nxt;
      used      <= used_eff + UW'(wr_en) - UW'(rd_en);
      pkt_cnt   <= pkt_cnt + CW'(commit) - CW'(start_data);
      rd_state  <= rd_state_nxt;
      rptr      <= rptr_nxt;
      rcnt      <= rcnt_nxt;
      ENA_OUT   <= ena_nxt;
      PSYNC_OUT <= psync_nxt;
      sel_data  <= sel_data_nxt;
      null_byte <= null_nxt;
      if (drop) OVF <= 1'b1;
    end
  end

  // Plain dual-port RAM with registered read so it maps onto block memory.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= DATA_IN;
    if (rd_en) rd_byte <= mem[rptr];
  end

  assign DATA_OUT = sel_data ? rd_byte : null_byte;

`ifdef STUFF_STATS_EN
  logic [15:0] null_cnt, drop_cnt;
  logic        null_start;

  assign null_start = TICK && (rd_state == R_IDLE) && (pkt_cnt == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      null_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (null_start && (null_cnt != 16'hFFFF)) null_cnt <= null_cnt + 16'd1;
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign NULL_CNT = null_cnt;
  assign DROP_CNT = drop_cnt;
`else
  assign NULL_CNT = '0;
  assign DROP_CNT = '0;
`endif

endmodule

// File: tb/tb_ts_null_stuffer.sv
// Testbench for ts_null_stuffer: packet-queue reference model checked every cycle,
// plus directed scenarios with literal expectations on the captured output stream.
module tb_ts_null_stuffer;

  localparam int PKT   = 188;
  localparam int DEPTH = 4 * PKT;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  DATA_IN;
  logic        ENA_IN;
  logic        PSYNC_IN;
  logic        TICK;
  logic [7:0]  DATA_OUT;
  logic        ENA_OUT;
  logic        PSYNC_OUT;
  logic        OVF;
  logic [15:0] NULL_CNT;
  logic [15:0] DROP_CNT;

  initial forever #5 CLK = ~CLK;

  ts_null_stuffer #(.FIFO_PKTS(4), .NULL_PID(13'h1FFF)) dut (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .ENA_IN(ENA_IN), .PSYNC_IN(PSYNC_IN),
    .TICK(TICK), .DATA_OUT(DATA_OUT), .ENA_OUT(ENA_OUT), .PSYNC_OUT(PSYNC_OUT),
    .OVF(OVF), .NULL_CNT(NULL_CNT), .DROP_CNT(DROP_CNT)
  );

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Reference model: committed bytes as a queue, partial packet separately.
  logic [7:0] byte_q[$];
  logic [7:0] part[$];
  logic [7:0] null_hdr[4] = '{8'h47, 8'h1F, 8'hFF, 8'h10};
  bit         filling, out_null, model_ok;
  int         avail, out_idx, exp_nulls, exp_drops;
  logic       exp_ena, exp_psync, exp_ovf;
  logic [7:0] exp_data;

  always @(posedge CLK) begin : model
    int old_used;
    int old_avail;
    bit dropped;
    if (RST) begin
      byte_q.delete(); part.delete();
      filling = 0; out_null = 0; avail = 0; out_idx = 0;
      exp_nulls = 0; exp_drops = 0;
      exp_ena = 0; exp_psync = 0; exp_ovf = 0; exp_data = 8'h00;
      model_ok = 1;
    end else begin
      old_used  = byte_q.size() + part.size();
      old_avail = avail;
      exp_ena   = 0;
      exp_psync = 0;
      if (TICK) begin
        if (out_idx == 0) begin
          out_null = (old_avail == 0);
          if (out_null) exp_nulls = (exp_nulls < 65535) ? exp_nulls + 1 : 65535;
          else avail--;
        end
        exp_ena   = 1;
        exp_psync = (out_idx == 0);
        if (out_null) exp_data = (out_idx < 4) ? null_hdr[out_idx] : 8'hFF;
        else          exp_data = byte_q.pop_front();
        out_idx = (out_idx + 1) % PKT;
      end
      dropped = 0;
      if (ENA_IN && PSYNC_IN) begin
        if (filling) begin
          old_used -= part.size();
          part.delete();
          dropped = 1;
        end
        if (DEPTH - old_used >= PKT) begin
          part.push_back(DATA_IN);
          filling = 1;
        end else begin
          dropped = 1;
          filling = 0;
        end
      end else if (ENA_IN && filling) begin
        part.push_back(DATA_IN);
        if (part.size() == PKT) begin
          foreach (part[i]) byte_q.push_back(part[i]);
          part.delete();
          filling = 0;
          avail++;
        end
      end
      if (dropped) begin
        exp_ovf   = 1;
        exp_drops = (exp_drops < 65535) ? exp_drops + 1 : 65535;
      end
    end
  end

  always @(negedge CLK) begin
    if (model_ok) begin
      checkOutput("ena_out", 32'(ENA_OUT), 32'(exp_ena));
      checkOutput("psync_out", 32'(PSYNC_OUT), 32'(exp_psync));
      checkOutput("ovf", 32'(OVF), 32'(exp_ovf));
      if (exp_ena) checkOutput("data_out", 32'(DATA_OUT), 32'(exp_data));
`ifdef STUFF_STATS_EN
      checkOutput("null_cnt", 32'(NULL_CNT), 32'(exp_nulls));
      checkOutput("drop_cnt", 32'(DROP_CNT), 32'(exp_drops));
`else
      checkOutput("null_cnt", 32'(NULL_CNT), 32'd0);
      checkOutput("drop_cnt", 32'(DROP_CNT), 32'd0);
`endif
    end
  end

  // Output stream capture: {PSYNC_OUT, DATA_OUT} per valid byte.
  logic [8:0] out_log[$];
  always @(posedge CLK) begin
    #1;
    if (ENA_OUT === 1'b1) out_log.push_back({PSYNC_OUT, DATA_OUT});
  end

  task automatic checkLog(input string name, input int idx, input logic [8:0] expected);
    logic [8:0] actual;
    actual = (idx < out_log.size()) ? out_log[idx] : 9'bx;
    checkOutput(name, 32'(actual), 32'(expected));
  endtask

  task automatic checkStats(input string name, input int nulls, input int drops);
`ifdef STUFF_STATS_EN
    checkOutput({name, "_null_cnt"}, 32'(NULL_CNT), 32'(nulls));
    checkOutput({name, "_drop_cnt"}, 32'(DROP_CNT), 32'(drops));
`else
    checkOutput({name, "_null_cnt"}, 32'(NULL_CNT), 32'd0);
    checkOutput({name, "_drop_cnt"}, 32'(DROP_CNT), 32'd0);
`endif
  endtask

  int tick_period = 1;
  int tick_phase  = 0;
  int tick_budget = 0;

  task automatic applyStimulus(input logic ena, input logic psync, input logic [7:0] d);
    @(negedge CLK);
    RST = 0; ENA_IN = ena; PSYNC_IN = psync; DATA_IN = d; TICK = 0;
    if (tick_budget > 0) begin
      if (tick_phase == 0) begin
        TICK = 1;
        tick_budget--;
      end
      tick_phase = (tick_phase + 1) % tick_period;
    end
  endtask

  task automatic startTicks(input int period, input int count);
    tick_period = period;
    tick_phase  = 0;
    tick_budget = count;
  endtask

  task automatic drainTicks();
    while (tick_budget > 0) applyStimulus(0, 0, 8'h00);
    repeat (3) applyStimulus(0, 0, 8'h00);
  endtask

  task automatic doReset();
    @(negedge CLK);
    RST = 1; ENA_IN = 0; PSYNC_IN = 0; DATA_IN = 8'h00; TICK = 1; tick_budget = 0;
    @(negedge CLK);
    RST = 0; TICK = 0;
    out_log.delete();
  endtask

  function automatic logic [7:0] pktByte(input int id, input int i);
    case (i)
      0:       return 8'h47;
      1:       return 8'(id);
      2:       return 8'h64;
      3:       return 8'h10;
      default: return 8'(i - 4 + id);
    endcase
  endfunction

  task automatic writePacket(input int id, input int len, input int gap);
    for (int i = 0; i < len; i++) begin
      applyStimulus(1, i == 0, pktByte(id, i));
      for (int g = 0; g < gap; g++) applyStimulus(0, 0, 8'h00);
    end
  endtask

  initial begin
    int n;
    RST = 0; ENA_IN = 0; PSYNC_IN = 0; DATA_IN = 8'h00; TICK = 0;

    $display("[TB] scenario 1: idle input gives continuous null packets");
    doReset();
    checkOutput("rst_ena", 32'(ENA_OUT), 32'd0);
    checkOutput("rst_data", 32'(DATA_OUT), 32'd0);
    checkOutput("rst_ovf", 32'(OVF), 32'd0);
    startTicks(4, 564);
    drainTicks();
    checkOutput("t1_len", 32'(out_log.size()), 32'd564);
    checkLog("t1_b0", 0, 9'h147);
    checkLog("t1_b1", 1, 9'h01F);
    checkLog("t1_b2", 2, 9'h0FF);
    checkLog("t1_b3", 3, 9'h010);
    checkLog("t1_b4", 4, 9'h0FF);
    checkLog("t1_b188", 188, 9'h147);
    checkLog("t1_b376", 376, 9'h147);
    checkLog("t1_b563", 563, 9'h0FF);
    n = 0;
    foreach (out_log[i]) if (out_log[i][8]) n++;
    checkOutput("t1_psyncs", 32'(n), 32'd3);
    checkStats("t1", 3, 0);

    $display("[TB] scenario 2: packet arrives while a null packet is in flight");
    doReset();
    startTicks(4, 564);
    repeat (200) applyStimulus(0, 0, 8'h00);
    writePacket(0, PKT, 1);
    drainTicks();
    checkOutput("t2_len", 32'(out_log.size()), 32'd564);
    checkLog("t2_b187", 187, 9'h0FF);
    checkLog("t2_b188", 188, 9'h147);
    checkLog("t2_b189", 189, 9'h000);
    checkLog("t2_b190", 190, 9'h064);
    checkLog("t2_b191", 191, 9'h010);
    checkLog("t2_b192", 192, 9'h000);
    checkLog("t2_b375", 375, 9'h0B7);
    checkLog("t2_b376", 376, 9'h147);
    checkLog("t2_b377", 377, 9'h01F);

    $display("[TB] scenario 3: five packets into a four-packet buffer");
    doReset();
    for (int id = 1; id <= 5; id++) writePacket(id, PKT, 0);
    repeat (2) applyStimulus(0, 0, 8'h00);
    checkOutput("t3_ovf", 32'(OVF), 32'd1);
    checkStats("t3", 0, 1);
    startTicks(1, 4 * PKT);
    drainTicks();
    checkOutput("t3_len", 32'(out_log.size()), 32'd752);
    for (int k = 0; k < 4; k++) begin
      checkLog("t3_sync", k * PKT, 9'h147);
      checkLog("t3_id", k * PKT + 1, {1'b0, 8'(k + 1)});
      checkLog("t3_last", k * PKT + 187, {1'b0, 8'(184 + k)});
    end
    checkOutput("t3_ovf_sticky", 32'(OVF), 32'd1);

    $display("[TB] scenario 4: short packet followed by a full one");
    doReset();
    writePacket(7, 100, 0);
    writePacket(8, PKT, 0);
    repeat (2) applyStimulus(0, 0, 8'h00);
    checkOutput("t4_ovf", 32'(OVF), 32'd1);
    checkStats("t4", 0, 1);
    startTicks(1, 2 * PKT);
    drainTicks();
    checkOutput("t4_len", 32'(out_log.size()), 32'd376);
    checkLog("t4_b0", 0, 9'h147);
    checkLog("t4_b1", 1, 9'h008);
    checkLog("t4_b100", 100, 9'h068);
    checkLog("t4_b187", 187, 9'h0BF);
    checkLog("t4_b188", 188, 9'h147);
    checkLog("t4_b189", 189, 9'h01F);

    $display("[TB] scenario 5: commit coincides with the boundary tick");
    doReset();
    for (int i = 0; i < PKT - 1; i++) applyStimulus(1, i == 0, pktByte(9, i));
    startTicks(1, 2 * PKT);
    applyStimulus(1, 0, pktByte(9, PKT - 1));
    drainTicks();
    checkLog("t5_b0", 0, 9'h147);
    checkLog("t5_b1", 1, 9'h01F);
    checkLog("t5_b187", 187, 9'h0FF);
    checkLog("t5_b188", 188, 9'h147);
    checkLog("t5_b189", 189, 9'h009);
    checkLog("t5_b375", 375, 9'h0C0);

    $display("[TB] scenario 6: reset in the middle of a data packet");
    doReset();
    writePacket(10, 50, 0);
    writePacket(11, PKT, 0);
    applyStimulus(0, 0, 8'h00);
    checkOutput("t6_ovf_set", 32'(OVF), 32'd1);
    startTicks(1, 400);
    repeat (60) applyStimulus(0, 0, 8'h00);
    checkLog("t6_pre_b0", 0, 9'h147);
    checkLog("t6_pre_b1", 1, 9'h00B);
    doReset();
    checkOutput("t6_ena", 32'(ENA_OUT), 32'd0);
    checkOutput("t6_psync", 32'(PSYNC_OUT), 32'd0);
    checkOutput("t6_data", 32'(DATA_OUT), 32'd0);
    checkOutput("t6_ovf", 32'(OVF), 32'd0);
    checkStats("t6", 0, 0);
    startTicks(4, 8);
    drainTicks();
    checkOutput("t6_len", 32'(out_log.size()), 32'd8);
    checkLog("t6_b0", 0, 9'h147);
    checkLog("t6_b1", 1, 9'h01F);
    checkLog("t6_b3", 3, 9'h010);
    checkLog("t6_b4", 4, 9'h0FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
